// File: rtl/fc_primseq_rx.sv
// fc_primseq_rx -- receive-side primitive sequence detector.
//
// Classifies each word of the word-aligned, 8b/10b-decoded receive stream
// (K28.5 in byte 3) and reports which primitive sequence (NOS, OLS, LR, LRR)
// is currently recognized on the link. A sequence is recognized once
// RECOGNIZE_COUNT consecutive identical ordered sets have arrived; a run of
// fill words (IDLE/ARBFF, mixed freely) recognizes "no sequence".
//
// Parameters:
//   RECOGNIZE_COUNT  run length needed for recognition (2..15)
// Ports:
//   clk           core clock
//   reset_n       asynchronous active-low reset
//   data[31:0]    received word, byte 3 transmitted first
//   datak[3:0]    per-byte K flags; ordered sets carry 4'b1000
//   valid         data/datak qualify this cycle
//   rx_sync       PHY word sync; low clears the tracker and forces seq NONE
//   seq[2:0]      0=NONE 1=NOS 2=OLS 3=LR 4=LRR
//   seq_changed   one-cycle pulse when seq takes a new value
//   idle_seen     one-cycle pulse per valid IDLE word
//   arb_seen      one-cycle pulse per valid ARBFF word
//   bad_os_count  (FC_PRIMSEQ_RX_STATS_EN only) saturating count of
//                 K28.5-led words that match no known ordered set
//
// Build option: define FC_PRIMSEQ_RX_STATS_EN to add bad_os_count.

package fc;
    localparam logic [31:0] NOS   = 32'hBC55BF45;
    localparam logic [31:0] OLS   = 32'hBC358A55;
    localparam logic [31:0] LR    = 32'hBC49BF49;
    localparam logic [31:0] LRR   = 32'hBC35BF49;
    localparam logic [31:0] IDLE  = 32'hBC95B5B5;
    localparam logic [31:0] ARBFF = 32'hBC94FFFF;
    localparam logic [7:0]  K28_5 = 8'hBC;
endpackage

module fc_primseq_rx #(
    parameter int unsigned RECOGNIZE_COUNT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data,
    input  logic [3:0]  datak,
    input  logic        valid,
    input  logic        rx_sync,
    output logic [2:0]  seq,
    output logic        seq_changed,
    output logic        idle_seen,
    output logic        arb_seen
`ifdef FC_PRIMSEQ_RX_STATS_EN
    ,
    output logic [15:0] bad_os_count
`endif
);

    // Run tracker classes (last_class)
    //   state    | meaning
    //   CL_NONE  | no run in progress (after data, unknown OS, sync loss)
    //   CL_NOS   | run of NOS ordered sets
    //   CL_OLS   | run of OLS ordered sets
    //   CL_LR    | run of LR ordered sets
    //   CL_LRR   | run of LRR ordered sets
    //   CL_FILL  | run of IDLE/ARBFF fill words
    // CL_UNK and CL_DATA only classify the incoming word; they never persist.
    // Sequence encodings equal their seq output codes.
    typedef enum logic [2:0] {
        CL_NONE = 3'd0,
        CL_NOS  = 3'd1,
        CL_OLS  = 3'd2,
        CL_LR   = 3'd3,
        CL_LRR  = 3'd4,
        CL_FILL = 3'd5,
        CL_UNK  = 3'd6,
        CL_DATA = 3'd7
    } word_class_t;

    localparam logic [2:0] SEQ_NONE = 3'd0;
    localparam logic [3:0] RC       = 4'(RECOGNIZE_COUNT);
    localparam logic [3:0] RC_M1    = 4'(RECOGNIZE_COUNT - 1);

    word_class_t last_class, last_class_nxt, word_cls;
    logic [3:0]  run_cnt, run_cnt_nxt;
    logic [2:0]  seq_nxt;
    logic        seq_changed_nxt, idle_nxt, arb_nxt;
    logic        is_os, is_idle, is_arb;

    // Word classification
    always_comb begin
        is_os   = (datak == 4'b1000) && (data[31:24] == fc::K28_5);
        is_idle = is_os && (data == fc::IDLE);
        is_arb  = is_os && (data == fc::ARBFF);
        word_cls = CL_DATA;
        if (is_os) begin
            unique case (data)
                fc::NOS:            word_cls = CL_NOS;
                fc::OLS:            word_cls = CL_OLS;
                fc::LR:             word_cls = CL_LR;
                fc::LRR:            word_cls = CL_LRR;
                fc::IDLE, fc::ARBFF: word_cls = CL_FILL;
                default:            word_cls = CL_UNK;
            endcase
        end
    end

    always_comb begin
        last_class_nxt  = last_class;
        run_cnt_nxt     = run_cnt;
        seq_nxt         = seq;
        seq_changed_nxt = 1'b0;
        idle_nxt        = 1'b0;
        arb_nxt         = 1'b0;

        if (!rx_sync) begin
            last_class_nxt  = CL_NONE;
            run_cnt_nxt     = 4'd0;
            seq_nxt         = SEQ_NONE;
            seq_changed_nxt = (seq != SEQ_NONE);
        end else if (valid) begin
            idle_nxt = is_idle;
            arb_nxt  = is_arb;
            unique case (word_cls)
                CL_NOS, CL_OLS, CL_LR, CL_LRR, CL_FILL: begin
                    if (word_cls == last_class) begin
                        if (run_cnt != RC) begin
                            run_cnt_nxt = run_cnt + 4'd1;
                        end
                        // Fires only on the step that reaches RC; a saturated
                        // run stays quiet however long it lasts.
                        if (run_cnt == RC_M1) begin
                            seq_nxt = (word_cls == CL_FILL) ? SEQ_NONE : word_cls[2:0];
                            seq_changed_nxt = (seq_nxt != seq);
                        end
                    end else begin
                        last_class_nxt = word_cls;
                        run_cnt_nxt    = 4'd1;
                    end
                end
                default: begin
                    last_class_nxt = CL_NONE;
                    run_cnt_nxt    = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_class  <= CL_NONE;
            run_cnt     <= 4'd0;
            seq         <= SEQ_NONE;
            seq_changed <= 1'b0;
            idle_seen   <= 1'b0;
            arb_seen    <= 1'b0;
        end else begin
            last_class  <= last_class_nxt;
            run_cnt     <= run_cnt_nxt;
            seq         <= seq_nxt;
            seq_changed <= seq_changed_nxt;
            idle_seen   <= idle_nxt;
            arb_seen    <= arb_nxt;
        end
    end

`ifdef FC_PRIMSEQ_RX_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bad_os_count <= 16'd0;
        end else if (rx_sync && valid && (word_cls == CL_UNK) && (bad_os_count != 16'hFFFF)) begin
            bad_os_count <= bad_os_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fc_primseq_rx.sv
// Self-checking bench for fc_primseq_rx (RECOGNIZE_COUNT = 3).
// The driver issues one word (or gap) per cycle and pushes the hand-written
// expected output for the following cycle; the monitor pops and compares.
module tb_fc_primseq_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] data;
    logic [3:0]  datak;
    logic        valid;
    logic        rx_sync;
    logic [2:0]  seq;
    logic        seq_changed, idle_seen, arb_seen;
`ifdef FC_PRIMSEQ_RX_STATS_EN
    logic [15:0] bad_os_count;
`endif

    fc_primseq_rx #(.RECOGNIZE_COUNT(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .data        (data),
        .datak       (datak),
        .valid       (valid),
        .rx_sync     (rx_sync),
        .seq         (seq),
        .seq_changed (seq_changed),
        .idle_seen   (idle_seen),
        .arb_seen    (arb_seen)
`ifdef FC_PRIMSEQ_RX_STATS_EN
        ,
        .bad_os_count(bad_os_count)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [31:0] W_NOS  = 32'hBC55BF45;
    localparam logic [31:0] W_OLS  = 32'hBC358A55;
    localparam logic [31:0] W_LR   = 32'hBC49BF49;
    localparam logic [31:0] W_LRR  = 32'hBC35BF49;
    localparam logic [31:0] W_IDLE = 32'hBC95B5B5;
    localparam logic [31:0] W_ARB  = 32'hBC94FFFF;
    localparam logic [31:0] W_UNK  = 32'hBC000000;
    localparam logic [3:0]  K_OS   = 4'b1000;

    typedef struct {
        string      name;
        logic [2:0] seq;
        logic       chg;
        logic       idle;
        logic       arb;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // One stimulus cycle plus the output expected after the sampling edge.
    task automatic step(input string name, input logic v, input logic [31:0] d,
                        input logic [3:0] k, input logic s,
                        input logic [2:0] e_seq, input logic e_chg,
                        input logic e_idle, input logic e_arb);
        exp_t e;
        @(negedge clk);
        valid   = v;
        data    = d;
        datak   = k;
        rx_sync = s;
        e.name = name; e.seq = e_seq; e.chg = e_chg; e.idle = e_idle; e.arb = e_arb;
        exp_q.push_back(e);
    endtask

    task automatic word(input string name, input logic [31:0] d,
                        input logic [2:0] e_seq, input logic e_chg,
                        input logic e_idle, input logic e_arb);
        step(name, 1'b1, d, K_OS, 1'b1, e_seq, e_chg, e_idle, e_arb);
    endtask

    task automatic gap(input string name, input logic [2:0] e_seq);
        step(name, 1'b0, 32'h0, 4'h0, 1'b1, e_seq, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int budget = 0;
        @(negedge clk);
        valid = 1'b0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d entries left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if (seq !== 3'd0 || seq_changed !== 1'b0 || idle_seen !== 1'b0 || arb_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got seq=%0d chg=%b idle=%b arb=%b, want seq=0 chg=0 idle=0 arb=0",
                     name, seq, seq_changed, idle_seen, arb_seen);
        end
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        valid   = 1'b0;
        reset_n = 1'b0;
        #1;
        check_idle_outputs(name);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: every issued stimulus yields one output cycle to compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (seq !== e.seq || seq_changed !== e.chg || idle_seen !== e.idle || arb_seen !== e.arb) begin
                    n_bad++;
                    $display("FAIL %s: got seq=%0d chg=%b idle=%b arb=%b, want seq=%0d chg=%b idle=%b arb=%b",
                             e.name, seq, seq_changed, idle_seen, arb_seen,
                             e.seq, e.chg, e.idle, e.arb);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        valid   = 1'b0;
        data    = 32'h0;
        datak   = 4'h0;
        rx_sync = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
`ifdef FC_PRIMSEQ_RX_STATS_EN
        n_cmp++;
        if (bad_os_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_bad_os: got %h, want 0000", bad_os_count);
        end
`endif
        reset_n = 1'b1;

        // LR recognition, then a long run that must not re-pulse
        word("lr1", W_LR, 3'd0, 1'b0, 1'b0, 1'b0);
        word("lr2", W_LR, 3'd0, 1'b0, 1'b0, 1'b0);
        word("lr3", W_LR, 3'd3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) word("lr_sat", W_LR, 3'd3, 1'b0, 1'b0, 1'b0);
        gap("lr_gap", 3'd3);

        // DATA breaks an OLS run; a wrong K mask is also DATA
        async_reset("reset_before_ols");
        word("ols1", W_OLS, 3'd0, 1'b0, 1'b0, 1'b0);
        word("ols2", W_OLS, 3'd0, 1'b0, 1'b0, 1'b0);
        step("ols_data", 1'b1, W_OLS, 4'b0000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        word("ols3", W_OLS, 3'd0, 1'b0, 1'b0, 1'b0);
        word("ols4", W_OLS, 3'd0, 1'b0, 1'b0, 1'b0);
        word("ols5", W_OLS, 3'd2, 1'b1, 1'b0, 1'b0);

        // NOS, then IDLE fill returns seq to NONE
        word("nos1", W_NOS, 3'd2, 1'b0, 1'b0, 1'b0);
        step("nos_badk", 1'b1, W_NOS, 4'b1100, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        word("nos2", W_NOS, 3'd2, 1'b0, 1'b0, 1'b0);
        word("nos3", W_NOS, 3'd2, 1'b0, 1'b0, 1'b0);
        word("nos4", W_NOS, 3'd1, 1'b1, 1'b0, 1'b0);
        word("idle1", W_IDLE, 3'd1, 1'b0, 1'b1, 1'b0);
        word("idle2", W_IDLE, 3'd1, 1'b0, 1'b1, 1'b0);
        word("idle3", W_IDLE, 3'd0, 1'b1, 1'b1, 1'b0);
        word("idle4", W_IDLE, 3'd0, 1'b0, 1'b1, 1'b0);

        // valid-low gaps do not break a run
        word("gap_lr1", W_LR, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) gap("gap_hold", 3'd0);
        word("gap_lr2", W_LR, 3'd0, 1'b0, 1'b0, 1'b0);
        word("gap_lr3", W_LR, 3'd3, 1'b1, 1'b0, 1'b0);

        // IDLE and ARBFF form one fill run
        word("mix_idle", W_IDLE, 3'd3, 1'b0, 1'b1, 1'b0);
        word("mix_arb",  W_ARB,  3'd3, 1'b0, 1'b0, 1'b1);
        word("mix_idle2", W_IDLE, 3'd0, 1'b1, 1'b1, 1'b0);

        // Unknown ordered set breaks an LRR run
        word("lrr1", W_LRR, 3'd0, 1'b0, 1'b0, 1'b0);
        word("lrr2", W_LRR, 3'd0, 1'b0, 1'b0, 1'b0);
        word("lrr_unk", W_UNK, 3'd0, 1'b0, 1'b0, 1'b0);
        word("lrr3", W_LRR, 3'd0, 1'b0, 1'b0, 1'b0);
        word("lrr4", W_LRR, 3'd0, 1'b0, 1'b0, 1'b0);
        word("lrr5", W_LRR, 3'd4, 1'b1, 1'b0, 1'b0);

        // Sync loss overrides a valid IDLE word and forces NONE
        step("sync_lost", 1'b1, W_IDLE, K_OS, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        step("sync_lost2", 1'b1, W_IDLE, K_OS, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        word("sync_back", W_LRR, 3'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-run: the run restarts from zero
        word("mr_nos1", W_NOS, 3'd0, 1'b0, 1'b0, 1'b0);
        word("mr_nos2", W_NOS, 3'd0, 1'b0, 1'b0, 1'b0);
        drain();
        async_reset("reset_mid_run");
        word("mr_nos3", W_NOS, 3'd0, 1'b0, 1'b0, 1'b0);
        word("mr_nos4", W_NOS, 3'd0, 1'b0, 1'b0, 1'b0);
        word("mr_nos5", W_NOS, 3'd1, 1'b1, 1'b0, 1'b0);
        drain();

`ifdef FC_PRIMSEQ_RX_STATS_EN
        // Unknown words under sync loss are not counted
        step("unk_nosync", 1'b1, W_UNK, K_OS, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) word("unk_small", W_UNK, 3'd0, 1'b0, 1'b0, 1'b0);
        drain();
        n_cmp++;
        if (bad_os_count !== 16'd5) begin
            n_bad++;
            $display("FAIL bad_os_5: got %h, want 0005", bad_os_count);
        end
        for (int i = 0; i < 70000; i++) word("unk_bulk", W_UNK, 3'd0, 1'b0, 1'b0, 1'b0);
        drain();
        n_cmp++;
        if (bad_os_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL bad_os_sat: got %h, want ffff", bad_os_count);
        end
        word("unk_more", W_UNK, 3'd0, 1'b0, 1'b0, 1'b0);
        drain();
        n_cmp++;
        if (bad_os_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL bad_os_hold: got %h, want ffff", bad_os_count);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_primseq_rx.md
# fc_primseq_rx

Receive-side primitive sequence detector for the Fibre Channel framer. It consumes the word-aligned 32-bit 8b/10b-decoded stream from the PHY and classifies ordered sets, with K28.5 in the most significant byte. It reports which primitive sequence (NOS, OLS, LR, LRR) is currently recognized on the link. It feeds the port state machine, which drives the transmit-side state-to-ordered-set mapper.

## Interface
- `RECOGNIZE_COUNT`, 3: consecutive identical ordered sets required to recognize a primitive sequence (range 2–15).
- `clk`  in  1: core clock.
- `reset_n`  in  1: asynchronous active-low reset.
- `data`  in  32: received word; byte 3 is the first transmitted.
- `datak`  in  4: K-flags per byte; an ordered set requires `4'b1000`.
- `valid`  in  1: `data`/`datak` qualify this cycle.
- `rx_sync`  in  1: PHY word sync; low means the link is not synchronized.
- `seq`  out  3: recognized sequence. 0=NONE, 1=NOS, 2=OLS, 3=LR, 4=LRR.
- `seq_changed`  out  1: one-cycle pulse when `seq` takes a new value.
- `idle_seen`  out  1: one-cycle pulse per valid IDLE word.
- `arb_seen`  out  1: one-cycle pulse per valid ARBFF word.

## Operation
- Word classes use the `fc::` package constants:
  - NOS = 32'hBC55BF45
  - OLS = 32'hBC358A55
  - LR = 32'hBC49BF49
  - LRR = 32'hBC35BF49
  - IDLE = 32'hBC95B5B5
  - ARBFF = 32'hBC94FFFF
- A word is an ordered set only if `datak==4'b1000` and `data[31:24]==8'hBC`.
- Classes:
  - Sequence: one of NOS, OLS, LR, LRR.
  - FILL: IDLE or ARBFF.
  - UNKNOWN_OS: K28.5-led word with no matching pattern.
  - DATA: any other word.
- Run tracker registers:
  - `last_class`.
  - `run_cnt`, 4 bits, saturating at `RECOGNIZE_COUNT`.
- On each `valid` word:
  - Same sequence or FILL class as `last_class`: increment `run_cnt`.
  - Other sequence or FILL class: `last_class` takes the new class and `run_cnt` = 1.
  - DATA or UNKNOWN_OS: `run_cnt` = 0, and `last_class` = NONE.
- Recognition fires when `run_cnt` reaches `RECOGNIZE_COUNT`:
  - A sequence class sets `seq` to that sequence.
  - FILL sets `seq` to NONE.
- `seq` holds otherwise. DATA words and short runs never change `seq`.
- `seq_changed` pulses only if the new `seq` differs from the old one. Re-recognizing the same sequence does not pulse.
- `idle_seen`/`arb_seen` pulse on every valid IDLE/ARBFF word, independent of run length.
- `valid` low: no state change, all pulses low.
- `rx_sync` low has priority over `valid`:
  - `run_cnt` = 0, `last_class` = NONE.
  - `seq` forced to NONE, with a `seq_changed` pulse if `seq` was not NONE.
  - `idle_seen`/`arb_seen` stay low.

## Timing
- Every output is registered.
- Reset values:
  - `seq` = 0 (NONE).
  - `seq_changed` = 0, `idle_seen` = 0, `arb_seen` = 0.
  - `run_cnt` = 0, `last_class` = NONE.
- Latency:
  - The `RECOGNIZE_COUNT`-th consecutive identical word, sampled at edge N, updates `seq` and pulses `seq_changed` after edge N.
  - Both are visible in cycle N+1.
- `idle_seen`/`arb_seen` are visible the cycle after the word is sampled.
- Runs may be non-contiguous in time. `valid`-low gaps do not break a run.
- Saturation: `run_cnt` stops at `RECOGNIZE_COUNT`. An arbitrarily long sequence never wraps and never re-pulses.
- Asynchronous reset may assert mid-run. All state clears immediately, and a run in progress restarts from zero after release.

## Configuration
- `FC_PRIMSEQ_RX_STATS_EN` defined:
  - Adds output `bad_os_count` (16 bits), reset 0.
  - Increments on each valid UNKNOWN_OS word while `rx_sync` is high.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Reset, then 3 valid LR words → `seq`=3 and `seq_changed` pulses for one cycle in the cycle after the 3rd word. Then 10 more LR → no further pulse.
- OLS, OLS, DATA (`datak`=0), OLS, OLS → `seq` stays 0. A 3rd OLS after that → `seq`=2.
- With `seq`=1 (NOS), send 3 IDLE → `idle_seen` pulses 3 times, then `seq`=0 with a `seq_changed` pulse.
- LR, LR with `valid` low for 5 cycles between them, then a 3rd LR → `seq`=3 (gaps do not break the run).
- With `seq`=4, drop `rx_sync` for 1 cycle → `seq`=0 with a pulse. Assert `reset_n` low mid-run (after 2 NOS) → next NOS alone does not recognize.
- With `FC_PRIMSEQ_RX_STATS_EN` defined, send 32'hBC000000 (`datak`=4'b1000) 70000 times → `bad_os_count`=16'hFFFF and holds.
